// File: rtl/alu_input_latch.sv
// Operand latches (A, B, carry) for the combinational ALU, with a valid-pair
// tracker and sticky protocol-error flags. Every output comes straight from a flop.
module alu_input_latch #(
  parameter logic [7:0] defaultValue = 8'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] stackBusInput,
  input  logic [7:0] dataBusInput,
  input  logic [7:0] addressBusLowInput,
  input  logic       aLoadStackBus,
  input  logic       aLoadZero,
  input  logic       bLoadDataBus,
  input  logic       bLoadInvertedDataBus,
  input  logic       bLoadAddressBusLow,
  input  logic       carryLoadEnable,
  input  logic       carryIn,
  input  logic       aluConsume,
  input  logic       clearErrors,
  output logic [7:0] aOperand,
  output logic [7:0] bOperand,
  output logic       carryOperand,
  output logic       operandsReady,
  output logic       overwriteError,
  output logic       underrunError
);

  // Encoding is {A-valid, B-valid}.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    B_ONLY = 2'b01,
    A_ONLY = 2'b10,
    READY  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       carry_q, carry_d;
  logic       ready_q, ready_d;
  logic       overwrite_q, overwrite_d;
  logic       underrun_q, underrun_d;

  logic a_load, b_load, consume_ok, a_valid, b_valid;
  logic overwrite_evt, underrun_evt;

  always_comb begin
    a_load     = aLoadStackBus | aLoadZero;
    b_load     = bLoadDataBus | bLoadInvertedDataBus | bLoadAddressBusLow;
    consume_ok = aluConsume && (state_q == READY);

    a_d = a_q;
    if (aLoadStackBus)  a_d = stackBusInput;
    else if (aLoadZero) a_d = 8'h00;

    b_d = b_q;
    if (bLoadDataBus)              b_d = dataBusInput;
    else if (bLoadInvertedDataBus) b_d = ~dataBusInput;
    else if (bLoadAddressBusLow)   b_d = addressBusLowInput;

    carry_d = carryLoadEnable ? carryIn : carry_q;

    // Consume clears first; loads on the same edge then re-validate.
    a_valid = (state_q[1] & ~consume_ok) | a_load;
    b_valid = (state_q[0] & ~consume_ok) | b_load;
    state_d = state_t'({a_valid, b_valid});
    ready_d = a_valid & b_valid;

    // Reload of a valid latch counts as overwrite unless a real consume freed it.
    overwrite_evt = ~consume_ok & ((a_load & state_q[1]) | (b_load & state_q[0]));
    underrun_evt  = aluConsume & (state_q != READY);
    overwrite_d   = overwrite_evt | (overwrite_q & ~clearErrors);
    underrun_d    = underrun_evt | (underrun_q & ~clearErrors);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      a_q         <= defaultValue;
      b_q         <= defaultValue;
      carry_q     <= 1'b0;
      ready_q     <= 1'b0;
      overwrite_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      ready_q     <= ready_d;
      overwrite_q <= overwrite_d;
      underrun_q  <= underrun_d;
    end
  end

  assign aOperand       = a_q;
  assign bOperand       = b_q;
  assign carryOperand   = carry_q;
  assign operandsReady  = ready_q;
  assign overwriteError = overwrite_q;
  assign underrunError  = underrun_q;

endmodule

// File: tb/tb_alu_input_latch.sv
// Bench for alu_input_latch: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_input_latch;

  localparam logic [7:0] DEF = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] stackBusInput, dataBusInput, addressBusLowInput;
  logic       aLoadStackBus, aLoadZero;
  logic       bLoadDataBus, bLoadInvertedDataBus, bLoadAddressBusLow;
  logic       carryLoadEnable, carryIn, aluConsume, clearErrors;
  logic [7:0] aOperand, bOperand;
  logic       carryOperand, operandsReady, overwriteError, underrunError;

  int vectors = 0;
  int miscompares = 0;

  alu_input_latch #(.defaultValue(DEF)) dut (
    .clk(clk), .rst(rst),
    .stackBusInput(stackBusInput), .dataBusInput(dataBusInput),
    .addressBusLowInput(addressBusLowInput),
    .aLoadStackBus(aLoadStackBus), .aLoadZero(aLoadZero),
    .bLoadDataBus(bLoadDataBus), .bLoadInvertedDataBus(bLoadInvertedDataBus),
    .bLoadAddressBusLow(bLoadAddressBusLow),
    .carryLoadEnable(carryLoadEnable), .carryIn(carryIn),
    .aluConsume(aluConsume), .clearErrors(clearErrors),
    .aOperand(aOperand), .bOperand(bOperand), .carryOperand(carryOperand),
    .operandsReady(operandsReady), .overwriteError(overwriteError),
    .underrunError(underrunError)
  );

  always #5 clk = ~clk;

  // Behavioural model: two latches, two valid booleans, two sticky flags.
  logic [7:0] m_a, m_b;
  bit m_c, m_av, m_bv, m_ow, m_ur, m_init = 0;

  always @(posedge clk) begin
    bit la, lb, cons, ow_ev, ur_ev;
    if (rst) begin
      m_a = DEF; m_b = DEF; m_c = 0;
      m_av = 0; m_bv = 0; m_ow = 0; m_ur = 0;
      m_init = 1;
    end else if (m_init) begin
      la    = aLoadStackBus || aLoadZero;
      lb    = bLoadDataBus || bLoadInvertedDataBus || bLoadAddressBusLow;
      cons  = aluConsume && m_av && m_bv;
      ow_ev = !cons && ((la && m_av) || (lb && m_bv));
      ur_ev = aluConsume && !(m_av && m_bv);
      if (aLoadStackBus) m_a = stackBusInput;
      else if (aLoadZero) m_a = 8'h00;
      if (bLoadDataBus) m_b = dataBusInput;
      else if (bLoadInvertedDataBus) m_b = ~dataBusInput;
      else if (bLoadAddressBusLow) m_b = addressBusLowInput;
      if (carryLoadEnable) m_c = carryIn;
      if (cons) begin m_av = 0; m_bv = 0; end
      if (la) m_av = 1;
      if (lb) m_bv = 1;
      m_ow = ow_ev || (m_ow && !clearErrors);
      m_ur = ur_ev || (m_ur && !clearErrors);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      vectors++;
      if ({aOperand, bOperand, carryOperand, operandsReady, overwriteError, underrunError}
          !== {m_a, m_b, m_c, m_av && m_bv, m_ow, m_ur}) begin
        miscompares++;
        $display("FAIL model t=%0t dut a=%h b=%h c=%b rdy=%b ow=%b ur=%b want a=%h b=%h c=%b rdy=%b ow=%b ur=%b",
                 $time, aOperand, bOperand, carryOperand, operandsReady, overwriteError,
                 underrunError, m_a, m_b, m_c, m_av && m_bv, m_ow, m_ur);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stackBusInput = 0; dataBusInput = 0; addressBusLowInput = 0;
    aLoadStackBus = 0; aLoadZero = 0; bLoadDataBus = 0; bLoadInvertedDataBus = 0;
    bLoadAddressBusLow = 0; carryLoadEnable = 0; carryIn = 0;
    aluConsume = 0; clearErrors = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk("rst_a", aOperand, 8'hA5);
    chk("rst_b", bOperand, 8'hA5);
    chk("rst_c", {7'b0, carryOperand}, 8'h00);
    chk("rst_rdy", {7'b0, operandsReady}, 8'h00);
    chk("rst_err", {6'b0, overwriteError, underrunError}, 8'h00);

    stackBusInput = 8'h3C; aLoadStackBus = 1;
    tick();
    chk("a_only_a", aOperand, 8'h3C);
    chk("a_only_rdy", {7'b0, operandsReady}, 8'h00);
    dataBusInput = 8'h0F; bLoadInvertedDataBus = 1;
    tick();
    chk("pair_b", bOperand, 8'hF0);
    chk("pair_rdy", {7'b0, operandsReady}, 8'h01);

    aluConsume = 1; aLoadStackBus = 1; aLoadZero = 1; stackBusInput = 8'h77;
    bLoadDataBus = 1; bLoadAddressBusLow = 1; dataBusInput = 8'h12; addressBusLowInput = 8'h34;
    tick();
    chk("prio_a", aOperand, 8'h77);
    chk("prio_b", bOperand, 8'h12);
    chk("prio_rdy", {7'b0, operandsReady}, 8'h01);

    for (int i = 0; i < 3; i++) begin
      aluConsume = 1; aLoadStackBus = 1; bLoadDataBus = 1;
      stackBusInput = 8'(2*i+1); dataBusInput = 8'(2*i+2);
      tick();
      chk("pipe_a", aOperand, 8'(2*i+1));
      chk("pipe_b", bOperand, 8'(2*i+2));
      chk("pipe_rdy_err", {5'b0, operandsReady, overwriteError, underrunError}, 8'h04);
    end

    aluConsume = 1;
    tick();
    chk("consume_rdy", {7'b0, operandsReady}, 8'h00);
    chk("consume_keep_a", aOperand, 8'h05);
    aluConsume = 1;
    tick();
    chk("underrun", {5'b0, operandsReady, overwriteError, underrunError}, 8'h01);
    stackBusInput = 8'h11; aLoadStackBus = 1;
    tick();
    stackBusInput = 8'h22; aLoadStackBus = 1;
    tick();
    chk("overwrite_a", aOperand, 8'h22);
    chk("overwrite_flags", {5'b0, operandsReady, overwriteError, underrunError}, 8'h03);
    clearErrors = 1;
    tick();
    chk("clear_flags", {6'b0, overwriteError, underrunError}, 8'h00);

    stackBusInput = 8'h55; aLoadStackBus = 1;
    tick();
    rst = 1; aLoadStackBus = 1; stackBusInput = 8'h99;
    tick();
    chk("midrst_a", aOperand, 8'hA5);
    chk("midrst_rdy", {7'b0, operandsReady}, 8'h00);
    addressBusLowInput = 8'h9C; bLoadAddressBusLow = 1;
    tick();
    chk("b_only_b", bOperand, 8'h9C);
    chk("b_only_a_rdy", {aOperand[7:1], operandsReady}, {7'b1010010, 1'b0});

    for (int i = 0; i < 600; i++) begin
      rst                  = ($urandom_range(0, 49) == 0);
      stackBusInput        = 8'($urandom);
      dataBusInput         = 8'($urandom);
      addressBusLowInput   = 8'($urandom);
      aLoadStackBus        = ($urandom_range(0, 3) == 0);
      aLoadZero            = ($urandom_range(0, 3) == 0);
      bLoadDataBus         = ($urandom_range(0, 4) == 0);
      bLoadInvertedDataBus = ($urandom_range(0, 4) == 0);
      bLoadAddressBusLow   = ($urandom_range(0, 4) == 0);
      carryLoadEnable      = ($urandom_range(0, 1) == 0);
      carryIn              = 1'($urandom);
      aluConsume           = ($urandom_range(0, 2) == 0);
      clearErrors          = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      #2;
    end
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_input_latch.md
# alu_input_latch

Operand-side counterpart of the ALU result register in the 8227 dataflow. Captures the A and B operands and the carry-in for the combinational ALU from the internal buses: A from the stack bus or zero, B from the data bus (true or inverted) or the address bus low. A four-state tracker reports when a complete operand pair is present, accepts a consume strobe when the ALU result is registered, and flags protocol misuse with sticky error bits.

## Interface
- defaultValue, 8'b0, reset value of both operand latches
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stackBusInput  in  8  stack bus value
- dataBusInput  in  8  data bus value
- addressBusLowInput  in  8  address bus low value
- aLoadStackBus  in  1  load A from stackBusInput
- aLoadZero  in  1  load A with 8'h00
- bLoadDataBus  in  1  load B from dataBusInput
- bLoadInvertedDataBus  in  1  load B from ~dataBusInput
- bLoadAddressBusLow  in  1  load B from addressBusLowInput
- carryLoadEnable  in  1  load carry latch from carryIn
- carryIn  in  1  carry value
- aluConsume  in  1  ALU result captured this cycle; operands used
- clearErrors  in  1  clear sticky error flags
- aOperand  out  8  A latch to the combinational ALU
- bOperand  out  8  B latch to the combinational ALU
- carryOperand  out  1  carry latch
- operandsReady  out  1  A and B both valid
- overwriteError  out  1  sticky: valid operand reloaded before consume
- underrunError  out  1  sticky: consume without both operands valid

## Operation
- A source priority: aLoadStackBus > aLoadZero. No A enable: A holds.
- B source priority: bLoadDataBus > bLoadInvertedDataBus > bLoadAddressBusLow. No B enable: B holds.
- The carry latch loads whenever carryLoadEnable is high. It is independent of the tracker and of errors.
- Tracker states: EMPTY, A_ONLY, B_ONLY, READY. A_ONLY means A is valid and B is not; B_ONLY is the reverse.
- Any A load sets A-valid. Any B load sets B-valid. The state is the encoding of (A-valid, B-valid).
- aluConsume in READY clears both valid bits. Latch contents are retained, not zeroed.
- Loads in the same cycle as a consume take effect after the clear. Example: READY with consume and an A load goes to A_ONLY holding the new A. READY with consume and both loads stays READY with new values.
- aluConsume outside READY is ignored for state, sets underrunError, and changes no valid bit. Loads in that cycle still apply.
- Loading an already-valid latch with no consume in the same cycle:
  - the new value still overwrites the latch;
  - overwriteError is set;
  - the state is unchanged.
- clearErrors clears both sticky flags. An error event in the same cycle has priority, so the flag is set.
- operandsReady = (state == READY), decoded from the registered state.

## Timing
- Every output is driven directly from a flop; there is no combinational input-to-output path.
- Load latency is one cycle: a value enabled at edge N is visible on aOperand/bOperand after edge N.
- operandsReady rises the cycle after the second operand's load edge. It falls the cycle after the consuming edge, unless both latches reload on that edge.
- Reset (rst high at an edge), from any state including mid-pair:
  - aOperand = bOperand = defaultValue;
  - carryOperand = 0;
  - state EMPTY, so operandsReady = 0;
  - both error flags = 0;
  - all other inputs are ignored on that edge.
- Back-to-back operation: one operand pair per cycle is supported. Hold READY, assert consume plus both loads every cycle, and operandsReady stays high.

## Test plan
- Reset with defaultValue 8'hA5 -> aOperand = bOperand = 8'hA5, carryOperand = 0, operandsReady = 0, both errors 0.
- A and B loaded on consecutive cycles:
  - stimulus: stackBus 8'h3C with aLoadStackBus; next cycle dataBus 8'h0F with bLoadInvertedDataBus;
  - response: aOperand = 8'h3C, bOperand = 8'hF0, operandsReady high one cycle after the B load.
- Same-cycle priority:
  - stimulus: aLoadStackBus with aLoadZero (stackBus 8'h77); bLoadDataBus with bLoadAddressBusLow (data 8'h12, ABL 8'h34);
  - response: A = 8'h77, B = 8'h12, READY next cycle.
- Consume/reload pipeline:
  - stimulus: in READY, 3 cycles of consume plus both loads (values 1/2, 3/4, 5/6);
  - response: operandsReady continuously high, latches track each pair, no errors.
- Errors:
  - consume in EMPTY -> underrunError = 1, state EMPTY;
  - A reload in A_ONLY -> overwriteError = 1, new A value visible;
  - clearErrors -> both flags 0 next cycle.
- Reset mid-pair: load A = 8'h55, then rst -> EMPTY, aOperand = defaultValue; a subsequent B-only load gives B_ONLY with operandsReady = 0.
